// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch control between the PC register and decode, with imem
// req/ack, a one-entry instruction buffer and redirect flush. Define IF_STALL_CNT_EN for stall_cnt.
module if_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_in,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

  // Wraps modulo 2^ADDR_W by construction of the fixed-width sum.
  function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(32'd4);
  endfunction

  logic [1:0]        state_q, state_d;
  logic              imem_req_q, imem_req_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_data_q, inst_data_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              fetch_accept_s;
  logic              unused_target_lsb_s;

  assign unused_target_lsb_s = ^redirect_target[1:0];

  assign fetch_accept_s = (state_q == ST_FETCH) && imem_ack && !redirect_valid;

  // Next-state selection; a redirect overrides every other event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          state_d = imem_ack ? ST_FETCH : ST_DRAIN;
        end else if (imem_ack) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FULL: begin
        if (redirect_valid || inst_ready) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid || imem_ack) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register next values, derived from where the FSM lands.
  always_comb begin
    imem_req_d   = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    inst_valid_d = (state_d == ST_FULL);
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    if (fetch_accept_s) begin
      inst_data_d = imem_rdata;
      inst_pc_d   = pc_out;
    end else begin
      inst_data_d = inst_data_q;
      inst_pc_d   = inst_pc_q;
    end
  end

  // The PC moves only on an accepted fetch or a redirect; otherwise it holds.
  always_comb begin
    pc_in = pc_out;
    if (redirect_valid) begin
      pc_in = align_word(redirect_target);
    end else if (fetch_accept_s) begin
      pc_in = pc_plus4(pc_out);
    end else begin
      pc_in = pc_out;
    end
  end

  assign imem_addr = pc_out;

  // FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= imem_req_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign inst_valid = inst_valid_q;
  assign inst_data  = inst_data_q;
  assign inst_pc    = inst_pc_q;

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles spent waiting on an outstanding request.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (imem_req_q && !imem_ack && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register; cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stimulus pushes expected instructions, a monitor
// compares the buffered instruction whenever inst_valid is presented.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc_out;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_out          (pc_out),
    .pc_in           (pc_in),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The PC register the fetch unit drives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_out <= 32'd0;
    else       pc_out <= pc_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [31:0] p);
    exp_t e;
    e.data = d;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the presented instruction against the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (inst_valid === 1'b1 && redirect_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got data 0x%08h pc 0x%08h with nothing expected", inst_data, inst_pc);
      end else begin
        chk("mon_inst_data", inst_data, exp_q[0].data);
        chk("mon_inst_pc", inst_pc, exp_q[0].pc);
        if (inst_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
    redirect_valid = 1'b0; redirect_target = 32'd0; inst_ready = 1'b0;

    // Reset held three cycles, then one IDLE cycle
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    reset = 1'b0;
    #1 chk("idle_req", {31'd0, imem_req}, 32'd0);

    // First fetch at 0x0, zero-wait ack
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h2002000A; push_exp(32'h2002000A, 32'h0);
    #1;
    chk("fetch0_req", {31'd0, imem_req}, 32'd1);
    chk("fetch0_addr", imem_addr, 32'h0);
    chk("fetch0_pc_in", pc_in, 32'h4);

    // FULL with decode stalled for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); imem_ack = 1'b0; inst_ready = 1'b0;
      #1;
      chk("full_req", {31'd0, imem_req}, 32'd0);
      chk("full_valid", {31'd0, inst_valid}, 32'd1);
      chk("full_pc_hold", pc_in, 32'h4);
    end
    @(negedge clk); inst_ready = 1'b1;
    #1 chk("accept_pc_in", pc_in, 32'h4);

    // Redirect to 0x40 while fetching 0x4 without ack
    @(negedge clk); inst_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40;
    #1;
    chk("refetch_valid", {31'd0, inst_valid}, 32'd0);
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, 32'h4);
    chk("redir40_pc_in", pc_in, 32'h40);
    @(negedge clk); redirect_valid = 1'b0;
    #1;
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    chk("drain_pc_hold", pc_in, 32'h40);
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1 chk("drain_ack_pc_in", pc_in, 32'h40);

    // Redirect to 0x101 in the same cycle as an ack at 0x40
    @(negedge clk); imem_rdata = 32'h12345678; redirect_valid = 1'b1; redirect_target = 32'h101;
    #1;
    chk("after_drain_valid", {31'd0, inst_valid}, 32'd0);
    chk("after_drain_addr", imem_addr, 32'h40);
    chk("redir101_pc_in", pc_in, 32'h100);

    // Fetch at 0x100, then an ack while not requesting is ignored
    @(negedge clk); redirect_valid = 1'b0; imem_rdata = 32'h00A00093; push_exp(32'h00A00093, 32'h100);
    #1;
    chk("drop_valid", {31'd0, inst_valid}, 32'd0);
    chk("fetch100_addr", imem_addr, 32'h100);
    chk("fetch100_pc_in", pc_in, 32'h104);
    @(negedge clk); imem_rdata = 32'hBAD0BAD0; inst_ready = 1'b1;
    #1;
    chk("stray_ack_req", {31'd0, imem_req}, 32'd0);
    chk("stray_ack_pc_in", pc_in, 32'h104);

    // Fetch at 0x104, then redirect in FULL with decode ready
    @(negedge clk); imem_rdata = 32'h11111111; inst_ready = 1'b0; push_exp(32'h11111111, 32'h104);
    #1;
    chk("fetch104_valid", {31'd0, inst_valid}, 32'd0);
    chk("fetch104_addr", imem_addr, 32'h104);
    chk("fetch104_pc_in", pc_in, 32'h108);
    @(negedge clk); imem_ack = 1'b0; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h200; exp_q.delete();
    #1 chk("redir_full_pc_in", pc_in, 32'h200);

    // Redirect to the top word, drain, then fetch there and wrap
    @(negedge clk); inst_ready = 1'b0; redirect_target = 32'hFFFFFFFF;
    #1;
    chk("flush_valid", {31'd0, inst_valid}, 32'd0);
    chk("fetch200_addr", imem_addr, 32'h200);
    chk("redir_top_pc_in", pc_in, 32'hFFFFFFFC);
    @(negedge clk); redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h55555555;
    #1 chk("drain_top_addr", imem_addr, 32'hFFFFFFFC);
    @(negedge clk); imem_rdata = 32'hCAFEF00D; push_exp(32'hCAFEF00D, 32'hFFFFFFFC);
    #1 chk("wrap_pc_in", pc_in, 32'h0);
    @(negedge clk); imem_ack = 1'b0; inst_ready = 1'b1;
    #1 chk("wrap_full_valid", {31'd0, inst_valid}, 32'd1);
    @(negedge clk); inst_ready = 1'b0;
    #1;
    chk("wrap_next_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Reset again mid-run, then five wait cycles before the ack
    reset = 1'b1;
    #1;
    chk("rst2_req", {31'd0, imem_req}, 32'd0);
    chk("rst2_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst2_data", inst_data, 32'd0);
`ifdef IF_STALL_CNT_EN
    chk("rst2_stall", stall_cnt, 32'd0);
`endif
    @(negedge clk); reset = 1'b0;
    #1 chk("idle2_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); imem_ack = 1'b0;
      #1 chk("wait_req", {31'd0, imem_req}, 32'd1);
    end
    @(negedge clk); imem_ack = 1'b1; imem_rdata = 32'h00000013; push_exp(32'h00000013, 32'h0);
    #1;
`ifdef IF_STALL_CNT_EN
    chk("stall_cnt5", stall_cnt, 32'd5);
`endif
    chk("wait_pc_in", pc_in, 32'h4);
    @(negedge clk); imem_ack = 1'b0; inst_ready = 1'b1;
    #1 chk("wait_full_valid", {31'd0, inst_valid}, 32'd1);
    @(negedge clk); inst_ready = 1'b0;
    #1;
    chk("final_valid", {31'd0, inst_valid}, 32'd0);
    chk("final_addr", imem_addr, 32'h4);
`ifdef IF_STALL_CNT_EN
    chk("stall_cnt_hold", stall_cnt, 32'd5);
`endif
    #3;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
